// File: rtl/pdm_playback.sv
// Plays 8-bit signed samples out as a 1-bit pulse-density stream: a small FIFO feeds a
// first-order sigma-delta modulator that holds each sample for NUM_PDM_SAMPLES PDM steps.
module pdm_playback #(
    parameter int PDM_COUNT_PERIOD = 32,
    parameter int NUM_PDM_SAMPLES  = 256,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          pdm_clk_out,
    output logic                          pdm_out,
    output logic                          sample_consumed_out,
    output logic                          underflow_out
);

    localparam int SW = (PDM_COUNT_PERIOD > 1) ? $clog2(PDM_COUNT_PERIOD) : 1;
    localparam int HW = (NUM_PDM_SAMPLES > 1) ? $clog2(NUM_PDM_SAMPLES) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [SW-1:0] STEP_LAST = SW'(PDM_COUNT_PERIOD - 1);
    localparam logic [SW-1:0] CLK_HIGH  = SW'(PDM_COUNT_PERIOD / 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(NUM_PDM_SAMPLES - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    // Two's complement to offset binary: -128 maps to 0, +127 to 255.
    function automatic logic [7:0] to_offset_binary(input logic signed [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

    logic [SW-1:0]        step_cnt_q, step_cnt_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [7:0]           acc_q, acc_d;
    logic signed [7:0]    cur_sample_q, cur_sample_d;
    logic signed [7:0]    sel_sample;
    logic                 pdm_q, pdm_d;
    logic                 pdm_clk_q, pdm_clk_d;
    logic                 consumed_q, consumed_d;
    logic                 underflow_q, underflow_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [8:0]           sum;
    logic                 step, load, fifo_empty, push, pop;

    always_comb begin
        push       = sample_valid_in && sample_ready_out;
        step       = enable_in && (step_cnt_q == STEP_LAST);
        load       = step && (hold_cnt_q == '0);
        fifo_empty = (count_q == '0);
        pop        = load && !fifo_empty;

        // On a load step the modulator must see the freshly selected sample.
        sel_sample = cur_sample_q;
        if (load) begin
            sel_sample = fifo_empty ? 8'sd0 : $signed(mem_q[rd_ptr_q]);
        end
        sum = {1'b0, acc_q} + {1'b0, to_offset_binary(sel_sample)};

        step_cnt_d   = '0;
        hold_cnt_d   = '0;
        acc_d        = '0;
        cur_sample_d = '0;
        pdm_d        = 1'b0;
        if (enable_in) begin
            step_cnt_d   = step ? '0 : step_cnt_q + 1'b1;
            hold_cnt_d   = hold_cnt_q;
            acc_d        = acc_q;
            cur_sample_d = load ? sel_sample : cur_sample_q;
            pdm_d        = pdm_q;
            if (step) begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? '0 : hold_cnt_q + 1'b1;
                acc_d      = sum[7:0];
                pdm_d      = sum[8];
            end
        end
        // Registered from the next count so the rising edge lines up with the pdm_out update.
        pdm_clk_d   = enable_in && (step_cnt_d < CLK_HIGH);
        consumed_d  = pop;
        underflow_d = load && fifo_empty;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            step_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            acc_q        <= '0;
            cur_sample_q <= '0;
            pdm_q        <= 1'b0;
            pdm_clk_q    <= 1'b0;
            consumed_q   <= 1'b0;
            underflow_q  <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            acc_q        <= acc_d;
            cur_sample_q <= cur_sample_d;
            pdm_q        <= pdm_d;
            pdm_clk_q    <= pdm_clk_d;
            consumed_q   <= consumed_d;
            underflow_q  <= underflow_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign sample_ready_out    = (count_q < FIFO_FULL);
    assign fifo_count_out      = count_q;
    assign pdm_clk_out         = pdm_clk_q;
    assign pdm_out             = pdm_q;
    assign sample_consumed_out = consumed_q;
    assign underflow_out       = underflow_q;

endmodule

// File: tb/tb_pdm_playback.sv
// Bench for pdm_playback: a queue/arithmetic model of the playback rules is checked every
// cycle, and per-frame pulse densities and pulse timing are pinned to literal values.
module tb_pdm_playback;

    localparam int P = 32;
    localparam int N = 256;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       ready, pclk, pdm, cons, under;
    logic [$clog2(D):0] cnt;

    always #5 clk = ~clk;

    pdm_playback #(
        .PDM_COUNT_PERIOD(P),
        .NUM_PDM_SAMPLES (N),
        .FIFO_DEPTH      (D)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .enable_in          (enable),
        .sample_in          (sample),
        .sample_valid_in    (valid),
        .sample_ready_out   (ready),
        .fifo_count_out     (cnt),
        .pdm_clk_out        (pclk),
        .pdm_out            (pdm),
        .sample_consumed_out(cons),
        .underflow_out      (under)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: enabled-edge count decides steps and loads; queue is the FIFO.
    int m_q[$];
    int en_edges = 0;
    int m_acc = 0;
    int m_cur = 0;
    int m_sum = 0;
    bit m_pdm = 0, m_clk = 0, m_cons = 0, m_under = 0;
    bit m_push;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            en_edges = 0; m_acc = 0; m_cur = 0;
            m_pdm = 0; m_clk = 0; m_cons = 0; m_under = 0;
        end else begin
            m_push  = valid && (m_q.size() < D);
            m_cons  = 0;
            m_under = 0;
            if (!enable) begin
                en_edges = 0; m_acc = 0; m_cur = 0; m_pdm = 0; m_clk = 0;
            end else begin
                en_edges++;
                if (en_edges % P == 0) begin
                    if (((en_edges / P) - 1) % N == 0) begin
                        if (m_q.size() > 0) begin
                            m_cur = m_q.pop_front();
                            m_cons = 1;
                        end else begin
                            m_cur = 0;
                            m_under = 1;
                        end
                    end
                    m_sum = m_acc + m_cur + 128;
                    m_pdm = (m_sum >= 256);
                    m_acc = m_sum % 256;
                end
                m_clk = (en_edges % P) < (P / 2);
            end
            if (m_push) m_q.push_back(int'($signed(sample)));
        end
    end

    // Per-cycle comparison plus a frame monitor (1s counted once per PDM clock rise).
    int  tallies[$];
    int  pulse_cyc[$];
    int  pulse_kind[$];
    int  tally = 0;
    bit  in_frame = 0;
    logic prev_pclk = 1'b0;

    initial forever begin
        @(negedge clk);
        if (chk_on && !rst) begin
            chk("pdm_out", 32'(pdm), 32'(m_pdm));
            chk("pdm_clk_out", 32'(pclk), 32'(m_clk));
            chk("sample_consumed_out", 32'(cons), 32'(m_cons));
            chk("underflow_out", 32'(under), 32'(m_under));
            chk("fifo_count_out", 32'(cnt), m_q.size());
            chk("sample_ready_out", 32'(ready), 32'(m_q.size() < D));
            if (cons || under) begin
                if (in_frame) tallies.push_back(tally);
                tally = 0;
                in_frame = 1;
                pulse_cyc.push_back(cyc);
                pulse_kind.push_back(cons ? 1 : 0);
            end
            if (pclk && !prev_pclk) tally += int'(pdm);
            prev_pclk = pclk;
        end
    end

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cyc.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("pulse_count_reached", 32'(pulse_cyc.size() >= target), 1);
    endtask

    task automatic push_one(input logic [7:0] v);
        @(posedge clk); #2;
        valid = 1'b1; sample = v;
        @(posedge clk); #2;
        valid = 1'b0;
    endtask

    function automatic bit load_next();
        int e = en_edges + 1;
        return enable && (e % P == 0) && (((e / P) - 1) % N == 0);
    endfunction

    int exp_tally[7];
    int exp_kind[8];
    int v[17];
    logic [7:0] rnd;
    int hi, guard, nb, base, en_cyc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdm_out", 32'(pdm), 0);
        chk("rst_pdm_clk_out", 32'(pclk), 0);
        chk("rst_consumed", 32'(cons), 0);
        chk("rst_underflow", 32'(under), 0);
        chk("rst_fifo_count", 32'(cnt), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ready), 1);
        chk_on = 1'b1;

        // Density frames, underflow, mid-frame push, same-cycle write on a load
        push_one(8'h7F);
        push_one(8'h00);
        push_one(8'h80);
        @(posedge clk); #2;
        enable = 1'b1;
        wait_pulses(4, 4 * P * N + 200);
        repeat ($urandom_range(100, 5000)) @(posedge clk);
        push_one(8'h40);
        wait_pulses(5, P * N + 200);
        hi = 0;
        repeat (P) begin
            @(negedge clk);
            hi += int'(pclk);
        end
        chk("pdm_clk_high_cycles", hi, P / 2);
        guard = 0;
        do begin
            @(posedge clk); #2;
            guard++;
        end while (!load_next() && guard < P * N + 100);
        chk("load_step_found", 32'(load_next()), 1);
        rnd = 8'($urandom_range(0, 255));
        valid = 1'b1; sample = rnd;
        @(posedge clk); #2;
        valid = 1'b0;
        chk("same_cycle_underflow", 32'(under), 1);
        chk("same_cycle_count", 32'(cnt), 1);
        wait_pulses(8, 3 * P * N + 200);

        exp_tally = '{255, 128, 0, 128, 192, 128, int'($signed(rnd)) + 128};
        exp_kind  = '{1, 1, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 7; i++) chk($sformatf("frame%0d_ones", i), tallies[i], exp_tally[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("pulse%0d_consumed", i), pulse_kind[i], exp_kind[i]);
        for (int i = 1; i < 8; i++) chk($sformatf("pulse%0d_spacing", i), pulse_cyc[i] - pulse_cyc[i-1], P * N);

        // Full FIFO while disabled, then consumption in write order
        @(posedge clk); #2;
        enable = 1'b0;
        for (int i = 0; i < 17; i++) v[i] = $urandom_range(0, 255);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #2;
            if (i == 15) chk("ready_before_16th", 32'(ready), 1);
            if (i == 16) begin
                chk("ready_after_16th", 32'(ready), 0);
                chk("count_full", 32'(cnt), 16);
            end
            valid = 1'b1; sample = 8'(v[i]);
        end
        @(posedge clk); #2;
        valid = 1'b0;
        chk("count_after_17th", 32'(cnt), 16);
        nb = pulse_cyc.size();
        base = tallies.size();
        @(posedge clk); #2;
        enable = 1'b1;
        en_cyc = cyc;
        wait_pulses(nb + 1, 4 * P);
        chk("enable_latency", pulse_cyc[nb] - en_cyc, P);
        chk("first_full_pop_consumed", pulse_kind[nb], 1);
        chk("count_after_pop", 32'(cnt), 15);
        wait_pulses(nb + 2, P * N + 200);
        chk("full_frame0_ones", tallies[base + 1], int'($signed(8'(v[0]))) + 128);
        chk("count_after_second_pop", 32'(cnt), 14);

        // Asynchronous reset mid-frame
        repeat ($urandom_range(50, 3000)) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_pdm_out", 32'(pdm), 0);
        chk("async_rst_pdm_clk_out", 32'(pclk), 0);
        chk("async_rst_consumed", 32'(cons), 0);
        chk("async_rst_underflow", 32'(under), 0);
        chk("async_rst_count", 32'(cnt), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("ready_after_async_rst", 32'(ready), 1);
        repeat (100) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_playback.md
Name: pdm_playback

Overview:
- Transmit-side counterpart of the microphone PDM decimator: converts 8-bit signed audio samples (~12 kHz) into a 1-bit pulse-density stream at the 3.072 MHz PDM step rate (98.3 MHz / 32), to drive the audio output / speaker filter.
- Samples arrive on a valid/ready handshake into an internal FIFO, for example from recorder playback.
- Each sample is held for NUM_PDM_SAMPLES PDM steps and modulated by a first-order sigma-delta loop.

Parameters:
- PDM_COUNT_PERIOD, 32, system clocks per PDM step. Even, ≥4.
- NUM_PDM_SAMPLES, 256, PDM steps per audio sample. Power of two, 256 for exact density.
- FIFO_DEPTH, 16, sample FIFO entries. Power of two.

Ports:
- clk_in  input  1  system clock (98.3 MHz)
- rst_in  input  1  asynchronous, active-high reset
- enable_in  input  1  playback enable
- sample_in  input  8  signed audio sample
- sample_valid_in  input  1  sample_in valid
- sample_ready_out  output  1  FIFO can accept a sample
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- pdm_clk_out  output  1  PDM clock, 50% duty
- pdm_out  output  1  pulse-density data
- sample_consumed_out  output  1  1-cycle pulse when a sample is popped
- underflow_out  output  1  1-cycle pulse when a sample load finds the FIFO empty

Behaviour:
- Reset (asynchronous, any time including mid-frame) clears every counter, the accumulator, the FIFO and all outputs immediately.
  - Outputs after reset: pdm_out=0, pdm_clk_out=0, sample_consumed_out=0, underflow_out=0, fifo_count_out=0.
  - sample_ready_out=1 once reset deasserts.
- FIFO:
  - Write when sample_valid_in && sample_ready_out.
  - sample_ready_out = (count < FIFO_DEPTH), combinational from the count register.
  - Write and pop in the same cycle leaves the count unchanged.
  - No bypass: a load on the same cycle as a write into an empty FIFO counts as underflow.
  - The FIFO accepts writes whether or not enable_in is high.
- Step generation:
  - step_cnt runs 0..PDM_COUNT_PERIOD-1 and wraps.
  - step = (step_cnt == PDM_COUNT_PERIOD-1), a 1-cycle strobe.
  - pdm_clk_out is registered and high while step_cnt < PDM_COUNT_PERIOD/2.
- Hold counter: hold_cnt runs 0..NUM_PDM_SAMPLES-1 and advances only on step.
- Load, on step with hold_cnt==0:
  - FIFO non-empty: pop the head into cur_sample and pulse sample_consumed_out on the next cycle.
  - FIFO empty: cur_sample←0 (midscale) and pulse underflow_out on the next cycle.
  - On the load step the modulator uses the newly selected value, not the stale cur_sample.
- Modulator, on each step:
  - u = {~s[7], s[6:0]} (offset binary, inverse of the receiver mapping).
  - sum = {1'b0, acc[7:0]} + u, 9 bits.
  - acc ← sum[7:0]; pdm_out ← sum[8].
  - pdm_out is registered and changes on the clock after step, coinciding with the pdm_clk_out rising edge.
  - Over any aligned NUM_PDM_SAMPLES=256-step frame, the count of 1s equals u exactly, because the accumulator starts below 256. Examples: s=0x7F→255, s=0x00→128, s=0x80→0.
- enable_in low (synchronous):
  - step_cnt, hold_cnt and acc are forced to 0, and cur_sample to 0.
  - pdm_out=0 and pdm_clk_out=0; no pops and no pulses.
- Enable rising: the first step occurs PDM_COUNT_PERIOD cycles later and performs a load.
- Disable mid-frame: the current sample is discarded (not returned to the FIFO); FIFO contents are kept.
- Only one of sample_consumed_out / underflow_out pulses per frame.

Test Plan:
- Reset: hold rst_in, assert it again asynchronously mid-frame → all outputs 0 within the same cycle, fifo_count_out=0; sample_ready_out=1 after release.
- Density: enable, push 0x7F, 0x00, 0x80 → per 8192-clock frame, 1s on pdm_out = 255, 128, 0; sample_consumed_out pulses exactly 8192 cycles apart.
- Full: with enable_in=0, write 17 samples back-to-back → first 16 accepted, sample_ready_out low from the cycle after the 16th, fifo_count_out=16, 17th dropped. Enable → 16 consumed pulses in write order.
- Underflow: enable with empty FIFO → underflow_out pulses once per frame and pdm_out carries 128 ones per frame. Push 0x40 mid-frame → next frame has 192 ones and exactly one sample_consumed_out.
- Same-cycle write and load into empty FIFO → underflow_out pulses, the sample remains in the FIFO (count=1) and is consumed at the next frame.
- Clocking: pdm_clk_out period = 32 cycles, 16 high; pdm_out transitions only on the cycle pdm_clk_out rises.
